fp_align_sequencer: RTL and testbench
=====================================

Name: fp_align_sequencer

Overview:
Multi-cycle alignment controller for the floating-point add/sub path. It accepts two unpacked operands (exponent plus mantissa with hidden bit) over a valid/ready handshake. It computes the exponent difference and swaps operands so the larger exponent leads. It then right-shifts the smaller mantissa at most ShiftStep bits per cycle, keeping guard/round/sticky bits, and presents the aligned pair to the adder stage over a second valid/ready handshake.

Parameters:
ExponentSize, 8, exponent width (5/8/11 for half/single/double).
MantissaSize, 23, stored fraction width; internal significand M = MantissaSize+1.
ShiftStep, 4, maximum right-shift distance per SHIFT cycle (1..M).

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
InValid  input  1  operand pair valid.
InReady  output  1  block can accept an operand pair.
Exponent1  input  ExponentSize  exponent of operand 1.
Exponent2  input  ExponentSize  exponent of operand 2.
Mantissa1  input  M  significand of operand 1, hidden bit included.
Mantissa2  input  M  significand of operand 2, hidden bit included.
OutValid  output  1  aligned result valid.
OutReady  input  1  downstream accepts result.
ResultExponent  output  ExponentSize  larger exponent.
AlignedLarge  output  M+3  larger-exponent significand followed by 3 zero bits.
AlignedSmall  output  M+3  shifted significand; bits [2:0] are guard, round, sticky.
Swapped  output  1  1 when Exponent2 > Exponent1.
Busy  output  1  high in any state other than IDLE.

Behaviour:
- Width W = M+3. Reset value of every output and register is 0, except InReady = 1. State after reset is IDLE.
- States are IDLE, COMPARE, SHIFT, DONE.
- IDLE: InReady=1. On InValid & InReady, capture all inputs and go to COMPARE.
- COMPARE (1 cycle):
  - If E2 > E1: Swapped=1, d=E2-E1, large operand = op2. Otherwise Swapped=0, d=E1-E2, large operand = op1.
  - Equal exponents give Swapped=0; mantissas are not compared.
  - Load ResultExponent, AlignedLarge = {Mlarge,3'b0}, AlignedSmall = {Msmall,3'b0}.
  - Remaining count R = min(d, W); the difference is unsigned, ExponentSize bits wide.
  - Go to DONE if R=0, otherwise go to SHIFT.
- SHIFT: each cycle s = min(R, ShiftStep).
  - AlignedSmall := AlignedSmall >> s, with new bit0 = (shifted value bit0) OR (OR of all s bits shifted out, including the old bit0).
  - R := R - s. Go to DONE when R reaches 0.
- DONE: OutValid=1 and all outputs are held stable. On OutReady, go to IDLE (OutValid drops the next cycle).
- There is no bypass from DONE to COMPARE. A new operand pair is accepted no earlier than the cycle after the output handshake.
- Latency: OutValid rises N = 1 + ceil(R/ShiftStep) edges after the accepting edge.
- OutReady held high before DONE has no effect. InValid outside IDLE is ignored; inputs are not re-sampled.
- Asserting Reset in any state returns to IDLE immediately (asynchronously) and clears outputs. An in-flight operation is discarded.
- Saturating R at W ensures a fully shifted-out operand leaves only the sticky bit = OR of the original significand.

Optional Feature:
Macro ALIGN_EARLY_FLUSH_EN.
- Defined: in COMPARE, if d >= W, load AlignedSmall = {(W-1)'b0, |Msmall} directly and go to DONE (N=1).
- Not defined: this case iterates in SHIFT with R=W, taking N = 1 + ceil(W/ShiftStep).
- Final output values are identical in both builds; only latency differs.

Decomposition:
- Package fp_align_pkg holds:
  - the state encoding (IDLE=2'd0, COMPARE=2'd1, SHIFT=2'd2, DONE=2'd3);
  - the guard/round/sticky width constant (3);
  - the width helper W = MantissaSize+4.
- One sub-module is natural: align_shift_step. It is combinational: W-bit input and shift amount 0..ShiftStep in, shifted W-bit value with sticky merged into bit0 out. It is instantiated once in the SHIFT datapath.

Test Plan:
- Single precision, E1=0x85, E2=0x80, M1=0xC00000, M2=0x800000 -> Swapped=0, ResultExponent=0x85, AlignedLarge=0x6000000, AlignedSmall=0x0200000 (sticky 0), OutValid 3 edges after accept.
- E1=0x80, E2=0x82, M1=0x800001, M2=0xA00000 -> Swapped=1, ResultExponent=0x82, AlignedSmall=0x1000002 (G=0,R=1,S=0), N=2.
- E1=E2=0x7F, any mantissas -> Swapped=0, no SHIFT cycles, AlignedSmall=Msmall<<3, N=1.
- E1=0xA8, E2=0x80 (d=40), M2=0x800000 -> AlignedSmall=0x0000001. N=8 without ALIGN_EARLY_FLUSH_EN, N=1 with it.
- Hold OutReady=0 for 5 cycles in DONE -> OutValid and outputs stable, InReady=0, second InValid ignored; the OutReady pulse returns the block to IDLE and InReady=1 the next cycle.
- Assert Reset during SHIFT of the d=40 case -> all outputs 0, InReady=1 without waiting for a clock edge; a new transaction after Reset releases completes correctly.

Source files
------------

// File: rtl/fp_align_pkg.sv
// Shared types and widths for the FP add/sub alignment sequencer.
// Optional build macro: ALIGN_EARLY_FLUSH_EN (see fp_align_sequencer).
package fp_align_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int GrsWidth = 3;

  // Aligned width: hidden bit + stored fraction + guard/round/sticky.
  function automatic int align_width(input int mantissa_size);
    return mantissa_size + 1 + GrsWidth;
  endfunction

endpackage

// File: rtl/align_shift_step.sv
// One right-shift step of the smaller significand.
// Every bit shifted out is folded into bit0 as sticky.
module align_shift_step #(
  parameter int Width     = 27,
  parameter int StepWidth = 3
) (
  input  logic [Width-1:0]     value_i,
  input  logic [StepWidth-1:0] amount_i,
  output logic [Width-1:0]     value_o
);

  logic [Width-1:0] lost_mask;
  logic [Width-1:0] shifted;
  logic             sticky;

  always_comb begin
    lost_mask = ~({Width{1'b1}} << amount_i);
    sticky    = |(value_i & lost_mask);
    shifted   = value_i >> amount_i;
    value_o   = {shifted[Width-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/fp_align_sequencer.sv
// Multi-cycle exponent compare/swap and sticky-preserving mantissa alignment.
// ALIGN_EARLY_FLUSH_EN: resolve fully shifted-out operands directly in COMPARE.
module fp_align_sequencer
  import fp_align_pkg::*;
#(
  parameter int ExponentSize = 8,
  parameter int MantissaSize = 23,
  parameter int ShiftStep    = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [ExponentSize-1:0] Exponent1,
  input  logic [ExponentSize-1:0] Exponent2,
  input  logic [MantissaSize:0]   Mantissa1,
  input  logic [MantissaSize:0]   Mantissa2,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [ExponentSize-1:0] ResultExponent,
  output logic [MantissaSize+3:0] AlignedLarge,
  output logic [MantissaSize+3:0] AlignedSmall,
  output logic                    Swapped,
  output logic                    Busy
);

  localparam int M     = MantissaSize + 1;
  localparam int W     = align_width(MantissaSize);
  localparam int CntW  = $clog2(W + 1);
  localparam int StepW = $clog2(ShiftStep + 1);

  state_e                  state_q, state_d;
  logic [ExponentSize-1:0] e1_q, e1_d;
  logic [ExponentSize-1:0] e2_q, e2_d;
  logic [M-1:0]            m1_q, m1_d;
  logic [M-1:0]            m2_q, m2_d;
  logic [ExponentSize-1:0] exp_q, exp_d;
  logic [W-1:0]            large_q, large_d;
  logic [W-1:0]            small_q, small_d;
  logic                    swap_q, swap_d;
  logic [CntW-1:0]         rem_q, rem_d;

  logic                    e2_gt;
  logic [ExponentSize-1:0] diff;
  logic [31:0]             diff_ext;
  logic [CntW-1:0]         rem_init;
  logic [StepW-1:0]        step;
  logic [M-1:0]            m_large;
  logic [M-1:0]            m_small;
  logic [W-1:0]            small_shifted;

  always_comb begin
    e2_gt    = e2_q > e1_q;
    diff     = e2_gt ? (e2_q - e1_q) : (e1_q - e2_q);
    diff_ext = 32'(diff);
    // Saturate at W: beyond that only the sticky bit survives anyway.
    rem_init = (diff_ext >= 32'(W)) ? CntW'(W) : CntW'(diff_ext);
    step     = (rem_q > CntW'(ShiftStep)) ? StepW'(ShiftStep)
                                          : StepW'(rem_q);
    m_large  = e2_gt ? m2_q : m1_q;
    m_small  = e2_gt ? m1_q : m2_q;
  end

  align_shift_step #(
    .Width    (W),
    .StepWidth(StepW)
  ) u_step (
    .value_i (small_q),
    .amount_i(step),
    .value_o (small_shifted)
  );

  always_comb begin
    state_d = state_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    exp_d   = exp_q;
    large_d = large_q;
    small_d = small_q;
    swap_d  = swap_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (InValid) begin
          e1_d    = Exponent1;
          e2_d    = Exponent2;
          m1_d    = Mantissa1;
          m2_d    = Mantissa2;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        swap_d  = e2_gt;
        exp_d   = e2_gt ? e2_q : e1_q;
        large_d = {m_large, {GrsWidth{1'b0}}};
        small_d = {m_small, {GrsWidth{1'b0}}};
        rem_d   = rem_init;
        state_d = (rem_init == '0) ? DONE : SHIFT;
`ifdef ALIGN_EARLY_FLUSH_EN
        if (rem_init == CntW'(W)) begin
          small_d = {{(W-1){1'b0}}, |m_small};
          rem_d   = '0;
          state_d = DONE;
        end
`endif
      end
      SHIFT: begin
        small_d = small_shifted;
        rem_d   = rem_q - CntW'(step);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      e1_q    <= '0;
      e2_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      exp_q   <= '0;
      large_q <= '0;
      small_q <= '0;
      swap_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      exp_q   <= exp_d;
      large_q <= large_d;
      small_q <= small_d;
      swap_q  <= swap_d;
      rem_q   <= rem_d;
    end
  end

  assign InReady        = (state_q == IDLE);
  assign OutValid       = (state_q == DONE);
  assign Busy           = (state_q != IDLE);
  assign ResultExponent = exp_q;
  assign AlignedLarge   = large_q;
  assign AlignedSmall   = small_q;
  assign Swapped        = swap_q;

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Randomized bench for fp_align_sequencer against a one-shot shift model.
// Honors ALIGN_EARLY_FLUSH_EN when computing expected latency.
module tb_fp_align_sequencer;

  localparam int ES   = 8;
  localparam int MS   = 23;
  localparam int STEP = 4;
  localparam int M    = MS + 1;
  localparam int W    = MS + 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [ES-1:0] Exponent1;
  logic [ES-1:0] Exponent2;
  logic [M-1:0]  Mantissa1;
  logic [M-1:0]  Mantissa2;
  logic          OutValid;
  logic          OutReady;
  logic [ES-1:0] ResultExponent;
  logic [W-1:0]  AlignedLarge;
  logic [W-1:0]  AlignedSmall;
  logic          Swapped;
  logic          Busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_align_sequencer #(
    .ExponentSize(ES),
    .MantissaSize(MS),
    .ShiftStep   (STEP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .InValid       (InValid),
    .InReady       (InReady),
    .Exponent1     (Exponent1),
    .Exponent2     (Exponent2),
    .Mantissa1     (Mantissa1),
    .Mantissa2     (Mantissa2),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .ResultExponent(ResultExponent),
    .AlignedLarge  (AlignedLarge),
    .AlignedSmall  (AlignedSmall),
    .Swapped       (Swapped),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, InReady, 1);
    check({tag, "_out_valid"}, OutValid, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_exp"}, ResultExponent, 0);
    check({tag, "_large"}, AlignedLarge, 0);
    check({tag, "_small"}, AlignedSmall, 0);
    check({tag, "_swapped"}, Swapped, 0);
  endtask

  task automatic run_txn(input logic [ES-1:0] e1, input logic [ES-1:0] e2,
                         input logic [M-1:0] m1, input logic [M-1:0] m2,
                         input int hold, input bit early);
    int d;
    int r;
    int n;
    int cnt;
    bit sw;
    logic [63:0] xl;
    logic [63:0] vs;
    logic [63:0] xs;
    logic [ES-1:0] xe;
    sw = e2 > e1;
    d  = sw ? int'(e2) - int'(e1) : int'(e1) - int'(e2);
    xe = sw ? e2 : e1;
    xl = 64'(sw ? m2 : m1) << 3;
    vs = 64'(sw ? m1 : m2) << 3;
    if (d >= W) xs = (vs != 0) ? 64'd1 : 64'd0;
    else xs = (vs >> d) | (((vs & ((64'd1 << d) - 1)) != 0) ? 64'd1 : 64'd0);
    r = (d < W) ? d : W;
    n = 1 + (r + STEP - 1) / STEP;
`ifdef ALIGN_EARLY_FLUSH_EN
    if (d >= W) n = 1;
`endif
    cnt = 0;
    while (!InReady && cnt < 50) begin
      @(posedge Clk); #1;
      cnt++;
    end
    check("pre_in_ready", InReady, 1);
    Exponent1 = e1;
    Exponent2 = e2;
    Mantissa1 = m1;
    Mantissa2 = m2;
    InValid   = 1'b1;
    OutReady  = early;
    @(posedge Clk); #1;
    InValid   = 1'b0;
    Exponent1 = ES'($urandom);
    Exponent2 = ES'($urandom);
    Mantissa1 = M'($urandom);
    Mantissa2 = M'($urandom);
    check("busy", Busy, 1);
    check("in_ready_busy", InReady, 0);
    cnt = 0;
    while (!OutValid && cnt < 64) begin
      @(posedge Clk); #1;
      cnt++;
    end
    check("latency", cnt, n);
    check("exp", ResultExponent, xe);
    check("swapped", Swapped, sw);
    check("large", AlignedLarge, xl);
    check("small", AlignedSmall, xs);
    if (!early) begin
      repeat (hold) begin
        @(posedge Clk); #1;
        InValid = 1'b1;
        check("hold_valid", OutValid, 1);
        check("hold_in_ready", InReady, 0);
        check("hold_exp", ResultExponent, xe);
        check("hold_small", AlignedSmall, xs);
      end
      @(posedge Clk); #1;
      InValid  = 1'b0;
      OutReady = 1'b1;
    end
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check("valid_drop", OutValid, 0);
    check("in_ready_back", InReady, 1);
  endtask

  initial begin
    logic [ES-1:0] e1;
    logic [ES-1:0] e2;
    logic [M-1:0]  m1;
    logic [M-1:0]  m2;
    Reset     = 1'b1;
    InValid   = 1'b0;
    OutReady  = 1'b0;
    Exponent1 = '0;
    Exponent2 = '0;
    Mantissa1 = '0;
    Mantissa2 = '0;
    #2;
    check_idle_zero("reset");
    #20;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;

    run_txn(8'h85, 8'h80, 24'hC00000, 24'h800000, 0, 1'b0);
    run_txn(8'h80, 8'h82, 24'h800001, 24'hA00000, 0, 1'b0);
    run_txn(8'h7F, 8'h7F, 24'h9ABCDE, 24'hFFFFFF, 0, 1'b0);
    run_txn(8'hA8, 8'h80, 24'hC00000, 24'h800000, 5, 1'b0);
    run_txn(8'h80, 8'h9A, 24'h800003, 24'h800000, 0, 1'b0);
    run_txn(8'h9B, 8'h80, 24'h800000, 24'h800001, 0, 1'b1);
    run_txn(8'h00, 8'hFF, 24'h000000, 24'h800000, 1, 1'b0);
    run_txn(8'h90, 8'h84, 24'h812345, 24'h800FFF, 0, 1'b1);

    // Reset in the middle of a long alignment.
    Exponent1 = 8'hA8;
    Exponent2 = 8'h80;
    Mantissa1 = 24'h800000;
    Mantissa2 = 24'h800000;
    InValid   = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    run_txn(8'hA8, 8'h80, 24'hF00000, 24'h800000, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      e1 = ES'($urandom);
      if ($urandom_range(0, 3) == 0) e2 = ES'($urandom);
      else e2 = e1 + ES'($urandom_range(0, 60)) - ES'(30);
      m1 = {1'b1, 23'($urandom)};
      m2 = {1'b1, 23'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        m1[11:0] = '0;
        m2[11:0] = '0;
      end
      run_txn(e1, e2, m1, m2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
